// File: rtl/utopia1_atm_port.sv
// Utopia-1 ATM cell port: byte-wide Rx/Tx PHY interfaces with 53-byte
// core-side cell buffers and a VPI forwarding lookup table.
module utopia1_atm_port #(
  parameter int NumTx = 4,
  parameter int Asize = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lut_we,
  input  logic [Asize-1:0]      lut_waddr,
  input  logic [NumTx+11:0]     lut_wdata,
  input  logic [Asize-1:0]      lut_raddr,
  output logic [NumTx+11:0]     lut_rdata,
  input  logic [7:0]            rx_data,
  input  logic                  rx_soc,
  input  logic                  rx_clav,
  output logic                  rx_en_n,
  output logic [423:0]          rx_cell,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [423:0]          tx_cell,
  input  logic                  tx_valid,
  input  logic                  tx_selected,
  output logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_soc,
  output logic                  tx_en_n,
  input  logic                  tx_clav
);

  localparam int LutW = NumTx + 12;
  localparam int LutN = 2 ** Asize;

  typedef enum logic {
    RX_COLLECT,
    RX_HOLD
  } rx_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  // Table is never reset; contents come only from power-up init and writes
  logic [LutW-1:0] lut [LutN] = '{default: '0};

  always_ff @(posedge clk) begin
    if (lut_we) lut[lut_waddr] <= lut_wdata;
  end

  assign lut_rdata = lut[lut_raddr];

  rx_state_e      rx_state_q, rx_state_d;
  logic [5:0]     rx_cnt_q, rx_cnt_d;
  logic           rx_en_n_q, rx_en_n_d;
  logic           rx_valid_q, rx_valid_d;
  logic           rx_shift;
  logic [423:0]   rx_cell_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_en_n_d  = rx_en_n_q;
    rx_valid_d = rx_valid_q;
    rx_shift   = 1'b0;
    unique case (rx_state_q)
      RX_COLLECT: begin
        rx_en_n_d = 1'b0;
        if (!rx_en_n_q && rx_clav) begin
          if (rx_soc) begin
            rx_shift = 1'b1;
            rx_cnt_d = 6'd1;
          end else if (rx_cnt_q != 6'd0) begin
            rx_shift = 1'b1;
            rx_cnt_d = rx_cnt_q + 6'd1;
            if (rx_cnt_q == 6'd52) begin
              rx_en_n_d  = 1'b1;
              rx_valid_d = 1'b1;
              rx_state_d = RX_HOLD;
            end
          end
        end
      end
      RX_HOLD: begin
        rx_en_n_d = 1'b1;
        if (!rx_ready) begin
          rx_valid_d = 1'b0;
          rx_cnt_d   = 6'd0;
          rx_en_n_d  = 1'b0;
          rx_state_d = RX_COLLECT;
        end
      end
      default: ;
    endcase
  end

  // Bytes shift in from the bottom: after 53 shifts byte 0 sits at the top
  // and anything left from an abandoned partial cell has been pushed out.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_COLLECT;
      rx_cnt_q   <= 6'd0;
      rx_en_n_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_cell_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_en_n_q  <= rx_en_n_d;
      rx_valid_q <= rx_valid_d;
      if (rx_shift) rx_cell_q <= {rx_cell_q[415:0], rx_data};
    end
  end

  assign rx_en_n  = rx_en_n_q;
  assign rx_valid = rx_valid_q;
  assign rx_cell  = rx_cell_q;

  tx_state_e      tx_state_q, tx_state_d;
  logic [5:0]     tx_cnt_q, tx_cnt_d;
  logic [423:0]   tx_buf_q;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_soc_q, tx_soc_d;
  logic           tx_en_n_q, tx_en_n_d;
  logic           tx_ready_q, tx_ready_d;
  logic           tx_load, tx_shift;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_data_d  = tx_data_q;
    tx_soc_d   = tx_soc_q;
    tx_en_n_d  = tx_en_n_q;
    tx_ready_d = tx_ready_q;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid && tx_selected) begin
          tx_load    = 1'b1;
          tx_ready_d = 1'b0;
          tx_cnt_d   = 6'd0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_cnt_q == 6'd53) begin
          tx_en_n_d  = 1'b1;
          tx_soc_d   = 1'b0;
          tx_ready_d = 1'b1;
          tx_state_d = TX_IDLE;
        end else if (tx_clav) begin
          tx_shift  = 1'b1;
          tx_data_d = tx_buf_q[423:416];
          tx_soc_d  = (tx_cnt_q == 6'd0);
          tx_en_n_d = 1'b0;
          tx_cnt_d  = tx_cnt_q + 6'd1;
        end else begin
          tx_en_n_d = 1'b1;
          tx_soc_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 6'd0;
      tx_buf_q   <= '0;
      tx_data_q  <= 8'd0;
      tx_soc_q   <= 1'b0;
      tx_en_n_q  <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_soc_q   <= tx_soc_d;
      tx_en_n_q  <= tx_en_n_d;
      tx_ready_q <= tx_ready_d;
      if (tx_load) begin
        tx_buf_q <= tx_cell;
      end else if (tx_shift) begin
        tx_buf_q <= {tx_buf_q[415:0], 8'h00};
      end
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_soc   = tx_soc_q;
  assign tx_en_n  = tx_en_n_q;
  assign tx_ready = tx_ready_q;

endmodule

// File: tb/tb_utopia1_atm_port.sv
// Scoreboard bench for utopia1_atm_port: lookup table, Rx collection with
// pauses and resync, Tx transmission with flow control and mid-cell reset.
module tb_utopia1_atm_port;

  localparam int NumTx = 4;
  localparam int Asize = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               lut_we;
  logic [Asize-1:0]   lut_waddr;
  logic [NumTx+11:0]  lut_wdata;
  logic [Asize-1:0]   lut_raddr;
  logic [NumTx+11:0]  lut_rdata;
  logic [7:0]         rx_data;
  logic               rx_soc;
  logic               rx_clav;
  logic               rx_en_n;
  logic [423:0]       rx_cell;
  logic               rx_valid;
  logic               rx_ready;
  logic [423:0]       tx_cell;
  logic               tx_valid;
  logic               tx_selected;
  logic               tx_ready;
  logic [7:0]         tx_data;
  logic               tx_soc;
  logic               tx_en_n;
  logic               tx_clav;

  utopia1_atm_port #(.NumTx(NumTx), .Asize(Asize)) dut (
    .clk(clk), .rst(rst),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .lut_raddr(lut_raddr), .lut_rdata(lut_rdata),
    .rx_data(rx_data), .rx_soc(rx_soc), .rx_clav(rx_clav),
    .rx_en_n(rx_en_n), .rx_cell(rx_cell), .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_cell(tx_cell), .tx_valid(tx_valid), .tx_selected(tx_selected),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_soc(tx_soc),
    .tx_en_n(tx_en_n), .tx_clav(tx_clav)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tx_seen = 0;
  logic tx_toggle = 1'b0;

  logic [423:0] rx_q [$];
  logic [8:0]   tx_q [$];

  task automatic chk(input string tag, input logic [423:0] got,
                     input logic [423:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [423:0] build(input logic [7:0] base);
    logic [423:0] c;
    c = '0;
    for (int i = 0; i < 53; i++) c[423-8*i -: 8] = base + 8'(i);
    return c;
  endfunction

  task automatic rx_byte(input logic [7:0] d, input logic s);
    @(negedge clk);
    rx_data = d;
    rx_soc  = s;
    rx_clav = 1'b1;
  endtask

  task automatic rx_pause();
    @(negedge clk);
    rx_data = 8'hFF;
    rx_soc  = 1'b1;
    rx_clav = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] base, input int pause_every);
    for (int i = 0; i < 53; i++) begin
      if (pause_every > 0 && (i % pause_every) == pause_every - 1) rx_pause();
      rx_byte(base + 8'(i), i == 0);
    end
    rx_q.push_back(build(base));
  endtask

  // Called one cycle after the final byte; checks and consumes the cell
  task automatic rx_take(input string tag);
    logic [423:0] exp;
    @(negedge clk);
    rx_clav = 1'b0;
    rx_soc  = 1'b0;
    chk({tag, "_valid"}, 424'(rx_valid), 424'(1));
    chk({tag, "_en_n"}, 424'(rx_en_n), 424'(1));
    if (rx_q.size() == 0) begin
      chk({tag, "_unexpected"}, 424'(rx_valid), 424'(0));
    end else begin
      exp = rx_q.pop_front();
      chk({tag, "_cell"}, rx_cell, exp);
    end
    rx_ready = 1'b0;
    @(negedge clk);
    rx_ready = 1'b1;
    chk({tag, "_released"}, 424'(rx_valid), 424'(0));
    chk({tag, "_reopen"}, 424'(rx_en_n), 424'(0));
  endtask

  always @(negedge clk) begin
    if (tx_toggle) tx_clav = ~tx_clav;
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (!tx_en_n) begin
      tx_seen++;
      if (tx_q.size() == 0) begin
        chk("tx_unexpected_byte", 424'(tx_en_n), 424'(1));
      end else begin
        e = tx_q.pop_front();
        chk("tx_data", 424'(tx_data), 424'(e[7:0]));
        chk("tx_soc", 424'(tx_soc), 424'(e[8]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [423:0] c;
    int n;
    rst = 1'b1;
    lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0; lut_raddr = '0;
    rx_data = '0; rx_soc = 1'b0; rx_clav = 1'b0; rx_ready = 1'b1;
    tx_cell = '0; tx_valid = 1'b0; tx_selected = 1'b0; tx_clav = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_valid", 424'(rx_valid), 424'(0));
    chk("rst_rx_en_n", 424'(rx_en_n), 424'(1));
    chk("rst_rx_cell", rx_cell, 424'(0));
    chk("rst_tx_ready", 424'(tx_ready), 424'(1));
    chk("rst_tx_en_n", 424'(tx_en_n), 424'(1));
    chk("rst_tx_soc", 424'(tx_soc), 424'(0));
    chk("rst_tx_data", 424'(tx_data), 424'(0));
    chk("lut_init", 424'(lut_rdata), 424'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rx_en_after_rst", 424'(rx_en_n), 424'(0));

    lut_we = 1'b1; lut_waddr = 8'h05; lut_wdata = {4'b0101, 12'h123};
    lut_raddr = 8'h05;
    @(negedge clk);
    lut_we = 1'b0;
    chk("lut_rd_05", 424'(lut_rdata), 424'(16'h5123));
    lut_raddr = 8'h04;
    #1 chk("lut_rd_04", 424'(lut_rdata), 424'(0));
    lut_raddr = 8'h06;
    #1 chk("lut_rd_06", 424'(lut_rdata), 424'(0));

    rx_send(8'h00, 0);
    @(negedge clk);
    rx_clav = 1'b0;
    chk("rx1_valid", 424'(rx_valid), 424'(1));
    chk("rx1_byte0", 424'(rx_cell[423:416]), 424'(8'h00));
    chk("rx1_byte52", 424'(rx_cell[7:0]), 424'(8'h34));
    chk("rx1_en_n", 424'(rx_en_n), 424'(1));
    @(negedge clk);
    chk("rx1_hold_valid", 424'(rx_valid), 424'(1));
    rx_take("rx1");

    for (int i = 0; i < 3; i++) rx_byte(8'hEE, 1'b0);
    rx_send(8'h40, 7);
    rx_take("rx2");

    for (int i = 0; i < 20; i++) rx_byte(8'h60 + 8'(i), i == 0);
    for (int i = 0; i < 53; i++) begin
      rx_byte(8'h80 + 8'(i), i == 0);
      if (i == 33 || i == 52) chk("rx_resync_early", 424'(rx_valid), 424'(0));
    end
    rx_q.push_back(build(8'h80));
    rx_take("rx3");

    c = build(8'hA0);
    for (int i = 0; i < 53; i++) tx_q.push_back({i == 0, c[423-8*i -: 8]});
    @(negedge clk);
    tx_cell = c; tx_valid = 1'b1; tx_selected = 1'b1; tx_toggle = 1'b1;
    @(negedge clk);
    chk("tx_ready_busy", 424'(tx_ready), 424'(0));
    tx_cell = build(8'h11); tx_valid = 1'b0; tx_selected = 1'b0;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      #1;
      if (tx_ready) break;
      n++;
    end
    chk("tx1_ready_back", 424'(tx_ready), 424'(1));
    chk("tx1_bytes", 424'(tx_seen), 424'(53));
    chk("tx1_q_empty", 424'(tx_q.size()), 424'(0));
    chk("tx1_en_n_idle", 424'(tx_en_n), 424'(1));

    tx_toggle = 1'b0;
    tx_clav = 1'b1;
    c = build(8'h10);
    for (int i = 0; i < 10; i++) tx_q.push_back({i == 0, c[423-8*i -: 8]});
    @(negedge clk);
    tx_cell = c; tx_valid = 1'b1; tx_selected = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; tx_selected = 1'b0;
    n = 0;
    while (n < 100 && tx_seen < 63) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("tx2_reach_byte10", 424'(tx_seen), 424'(63));
    rst = 1'b1;
    @(negedge clk);
    chk("tx2_rst_en_n", 424'(tx_en_n), 424'(1));
    chk("tx2_rst_ready", 424'(tx_ready), 424'(1));
    chk("tx2_rst_soc", 424'(tx_soc), 424'(0));
    rst = 1'b0;
    repeat (70) @(negedge clk);
    #1;
    chk("tx2_no_more_bytes", 424'(tx_seen), 424'(63));
    chk("tx2_q_empty", 424'(tx_q.size()), 424'(0));
    chk("rx_q_empty", 424'(rx_q.size()), 424'(0));
    chk("lut_kept_after_rst", 424'(lut_rdata), 424'(0));
    lut_raddr = 8'h05;
    #1 chk("lut_05_after_rst", 424'(lut_rdata), 424'(16'h5123));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
